pc_fetch_ctrl: RTL and testbench

- Program counter register and next-PC selection for the fetch stage.
- Produces `next_pc` (PC+4), which feeds the branch adder. Consumes the branch adder's `branch_addr` and the jump target.
- Sequences fetch under hazard-unit stalls and debug-unit run/step control.
- Raises `halted` when the decode stage reports a halt instruction.

---
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter: next-PC selection, debug run/step sequencing,
// stall handling, halt capture and committed-fetch accounting.
module pc_fetch_ctrl #(
  parameter int unsigned     MSB      = 32,
  parameter logic [MSB-1:0]  RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run_en,
  input  logic           step_req,
  input  logic           restart,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [MSB-1:0] branch_addr,
  input  logic           jump_taken,
  input  logic [MSB-1:0] jump_addr,
  input  logic           halt_detect,
  output logic [MSB-1:0] pc,
  output logic [MSB-1:0] next_pc,
  output logic           fetch_valid,
  output logic           halted,
  output logic           misaligned,
  output logic [MSB-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [MSB-1:0] STEP_INC  = MSB'(PC_STEP);
  localparam logic [MSB-1:0] CNT_ONE   = MSB'(1);
  localparam logic [MSB-1:0] LOW2_MASK = MSB'(3);

  state_e         state_q, state_d;
  logic [MSB-1:0] pc_q, pc_d;
  logic [MSB-1:0] cnt_q, cnt_d;
  logic           fv_q, fv_d;
  logic           mis_q, mis_d;

  logic           advance;
  logic           load_target;
  logic [MSB-1:0] target_raw;
  logic [MSB-1:0] pc_inc;

  // Word-align a redirect target; low bits never reach the fetch address.
  function automatic logic [MSB-1:0] align_word(input logic [MSB-1:0] addr);
    return addr & ~LOW2_MASK;
  endfunction

  function automatic logic low_bits_set(input logic [MSB-1:0] addr);
    return |(addr & LOW2_MASK);
  endfunction

  assign pc_inc      = pc_q + STEP_INC;
  // Branch belongs to the older instruction, so it outranks a jump.
  assign load_target = branch_taken | jump_taken;
  assign target_raw  = branch_taken ? branch_addr : jump_addr;
  assign advance     = ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                       !stall && !halt_detect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fv_d    = 1'b0;
    mis_d   = mis_q;

    if (restart) begin
      state_d = ST_IDLE;
      pc_d    = RESET_PC;
      cnt_d   = '0;
      mis_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (halt_detect)   state_d = ST_HALTED;
          else if (run_en)   state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (halt_detect)   state_d = ST_HALTED;
          else if (!run_en)  state_d = ST_IDLE;
        end
        // A step waits out stalls and retires on its first free cycle.
        ST_STEP: begin
          if (halt_detect)   state_d = ST_HALTED;
          else if (!stall)   state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase

      if (advance) begin
        fv_d  = 1'b1;
        cnt_d = cnt_q + CNT_ONE;
        if (load_target) begin
          pc_d  = align_word(target_raw);
          mis_d = mis_q | low_bits_set(target_raw);
        end else begin
          pc_d  = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  assign pc          = pc_q;
  assign next_pc     = pc_inc;
  assign fetch_valid = fv_q;
  assign halted      = (state_q == ST_HALTED);
  assign misaligned  = mis_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each stimulus row queues the expected
// post-edge outputs, and each scenario task drains and compares them.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_en = 1'b0, step_req = 1'b0, restart = 1'b0, stall = 1'b0;
  logic        branch_taken = 1'b0, jump_taken = 1'b0, halt_detect = 1'b0;
  logic [31:0] branch_addr = '0, jump_addr = '0;
  logic [31:0] pc, next_pc, fetch_count;
  logic        fetch_valid, halted, misaligned;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic run, step, rs, stl, br;
    logic [31:0] ba;
    logic jt;
    logic [31:0] ja;
    logic hd;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc, npc, cnt;
    logic fv, h, m;
  } obs_t;

  obs_t sb[$];
  obs_t obs_q[$];

  pc_fetch_ctrl #(.MSB(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step_req(step_req),
    .restart(restart), .stall(stall), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .jump_taken(jump_taken), .jump_addr(jump_addr),
    .halt_detect(halt_detect), .pc(pc), .next_pc(next_pc),
    .fetch_valid(fetch_valid), .halted(halted), .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk_stim(input logic run, step, rs, stl, br,
                                    input logic [31:0] ba, input logic jt,
                                    input logic [31:0] ja, input logic hd);
    stim_t s;
    s.run = run; s.step = step; s.rs = rs; s.stl = stl; s.br = br;
    s.ba = ba; s.jt = jt; s.ja = ja; s.hd = hd;
    return s;
  endfunction

  function automatic obs_t mk_exp(input logic [31:0] p, c, input logic fv, h, m);
    obs_t e;
    e.pc = p; e.npc = p + 32'd4; e.cnt = c; e.fv = fv; e.h = h; e.m = m;
    return e;
  endfunction

  function automatic obs_t capture();
    obs_t o;
    o.pc = pc; o.npc = next_pc; o.cnt = fetch_count;
    o.fv = fetch_valid; o.h = halted; o.m = misaligned;
    return o;
  endfunction

  task automatic apply(input stim_t s, input obs_t e);
    run_en = s.run; step_req = s.step; restart = s.rs; stall = s.stl;
    branch_taken = s.br; branch_addr = s.ba; jump_taken = s.jt;
    jump_addr = s.ja; halt_detect = s.hd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back(capture());
  endtask

  task automatic test_reset();
    obs_t o, e;
    #2 rst_n = 1'b0;
    #1;
    o = capture();
    e = mk_exp(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
               o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run_seq();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h04, 1, 1, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h08, 2, 1, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h0C, 3, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h10, 4, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h10, 4, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL run_seq row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_priority();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(0,0,1,0,0,0,0,0,0), mk_exp(32'h000, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h000, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,1,32'h20,0), mk_exp(32'h020, 1, 1, 0, 0));
    apply(mk_stim(1,0,0,0,1,32'h100,1,32'h200,0), mk_exp(32'h100, 2, 1, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h104, 3, 1, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,1,32'h200,0), mk_exp(32'h200, 4, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL priority row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_stall();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(1,0,0,0,0,0,1,32'h40,0), mk_exp(32'h40, 5, 1, 0, 0));
    apply(mk_stim(1,0,0,1,1,32'h80,0,0,0), mk_exp(32'h40, 5, 0, 0, 0));
    apply(mk_stim(1,0,0,1,1,32'h80,0,0,0), mk_exp(32'h40, 5, 0, 0, 0));
    apply(mk_stim(1,0,0,1,1,32'h80,0,0,0), mk_exp(32'h40, 5, 0, 0, 0));
    apply(mk_stim(1,0,0,1,1,32'h83,1,32'h3,0), mk_exp(32'h40, 5, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h44, 6, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h48, 7, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h48, 7, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_step();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(0,0,1,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(0,1,0,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,1,32'h10,0), mk_exp(32'h10, 1, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h10, 1, 0, 0, 0));
    apply(mk_stim(0,1,0,1,0,0,0,0,0), mk_exp(32'h10, 1, 0, 0, 0));
    apply(mk_stim(0,0,0,1,0,0,0,0,0), mk_exp(32'h10, 1, 0, 0, 0));
    apply(mk_stim(0,0,0,1,0,0,0,0,0), mk_exp(32'h10, 1, 0, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h14, 2, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h14, 2, 0, 0, 0));
    apply(mk_stim(0,1,0,0,0,0,0,0,0), mk_exp(32'h14, 2, 0, 0, 0));
    apply(mk_stim(0,1,0,0,0,0,0,0,0), mk_exp(32'h18, 3, 1, 0, 0));
    apply(mk_stim(0,1,0,0,0,0,0,0,0), mk_exp(32'h18, 3, 0, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h1C, 4, 1, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h1C, 4, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL step row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_halt();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(0,0,1,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,1,32'h30,0), mk_exp(32'h30, 1, 1, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,1,32'h300,1), mk_exp(32'h30, 1, 0, 1, 0));
    apply(mk_stim(1,1,0,0,0,0,1,32'h300,0), mk_exp(32'h30, 1, 0, 1, 0));
    apply(mk_stim(1,1,0,0,1,32'h500,0,0,0), mk_exp(32'h30, 1, 0, 1, 0));
    apply(mk_stim(1,0,1,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_misalign_wrap();
    obs_t o, e;
    int row = 0;
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h000, 0, 0, 0, 0));
    apply(mk_stim(1,0,0,0,0,0,1,32'h103,0), mk_exp(32'h100, 1, 1, 0, 1));
    apply(mk_stim(1,0,0,0,0,0,1,32'h200,0), mk_exp(32'h200, 2, 1, 0, 1));
    apply(mk_stim(1,0,0,0,1,32'h301,0,0,0), mk_exp(32'h300, 3, 1, 0, 1));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h304, 4, 1, 0, 1));
    apply(mk_stim(1,0,0,0,0,0,1,32'hFFFF_FFFC,0), mk_exp(32'hFFFF_FFFC, 5, 1, 0, 1));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h000, 6, 1, 0, 1));
    apply(mk_stim(1,0,0,0,0,0,0,0,0), mk_exp(32'h004, 7, 1, 0, 1));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL misalign_wrap row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    int row = 0;
    run_en = 1'b1;
    step_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    o = capture();
    e = mk_exp(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL async_reset: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
               o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
    end
    @(negedge clk);
    run_en = 1'b0;
    step_req = 1'b0;
    rst_n = 1'b1;
    apply(mk_stim(0,0,0,0,0,0,1,32'h40,0), mk_exp(32'h00, 0, 0, 0, 0));
    apply(mk_stim(0,0,0,0,0,0,0,0,0), mk_exp(32'h00, 0, 0, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset row %0d: got pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h npc=%h cnt=%0d fv=%b h=%b m=%b",
                 row, o.pc, o.npc, o.cnt, o.fv, o.h, o.m, e.pc, e.npc, e.cnt, e.fv, e.h, e.m);
      end
      row++;
    end
  endtask

  initial begin
    test_reset();
    test_run_seq();
    test_priority();
    test_stall();
    test_step();
    test_halt();
    test_misalign_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
